// File: rtl/button_pkg.sv
// Shared definitions for the push-button event classifier.
// State encodings are plain 3-bit constants; the tick defaults assume a 50 MHz clock.
package button_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRESSED  = 3'd1;
  localparam logic [2:0] ST_LONG     = 3'd2;
  localparam logic [2:0] ST_WAIT2    = 3'd3;
  localparam logic [2:0] ST_PRESSED2 = 3'd4;

  localparam int DEF_NBITS        = 26;
  localparam int DEF_LONG_TICKS   = 50_000_000;  // 1 s
  localparam int DEF_DCLICK_TICKS = 15_000_000;  // 300 ms
  localparam int DEF_REPEAT_TICKS = 10_000_000;  // 200 ms

endpackage

// File: rtl/event_timer.sv
// Saturating NBITS cycle timer with synchronous clear and a terminal-count flag.
// o_tc is high while the count equals i_limit-1, so an event scheduled for
// "limit cycles after clear" takes effect on the edge that sees o_tc.
module event_timer #(
  parameter int NBITS = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [NBITS-1:0] i_limit,
  output logic             o_tc
);

  localparam logic [NBITS-1:0] ONE     = NBITS'(1);
  localparam logic [NBITS-1:0] CNT_MAX = '1;

  logic [NBITS-1:0] r_count;

  // Count up while enabled, stick at all-ones, restart from zero on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_tc = (r_count == (i_limit - ONE));

endmodule

// File: rtl/button_event.sv
// Push-button event classifier: press/release edges, short click, double click
// and long press, all as registered one-cycle pulses, plus a held level.
// Optional build macro BUTTON_REPEAT_EN: long_press auto-repeats every
// REPEAT_TICKS cycles while the button stays held after a long press.
// The port "release" collides with a SystemVerilog keyword and is o_release.
module button_event
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int NBITS        = DEF_NBITS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press,
  output logic o_release,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam logic [NBITS-1:0] LONG_LIM   = NBITS'(LONG_TICKS);
  localparam logic [NBITS-1:0] DCLICK_LIM = NBITS'(DCLICK_TICKS);
  localparam logic [NBITS-1:0] REPEAT_LIM = NBITS'(REPEAT_TICKS);

  logic             r_btn_q;
  logic [2:0]       r_state;
  logic             r_press, r_release, r_short, r_double, r_long;

  logic             w_p, w_rise, w_fall, w_tc;
  logic [2:0]       w_state_next;
  logic             w_clear, w_short, w_double, w_long;
  logic [NBITS-1:0] w_limit;

  assign w_p    = btn_in ^ ACTIVE_LOW;
  assign w_rise = w_p & ~r_btn_q;
  assign w_fall = ~w_p & r_btn_q;

  // Pick the timeout that matters in the current state. In LONG the compare
  // result is only consumed by the auto-repeat build.
  always_comb begin
    w_limit = LONG_LIM;
    case (r_state)
      ST_WAIT2: w_limit = DCLICK_LIM;
      ST_LONG:  w_limit = REPEAT_LIM;
      default:  w_limit = LONG_LIM;
    endcase
  end

  event_timer #(.NBITS(NBITS)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_en    (1'b1),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Next-state logic: edges are tested before timeouts so an edge coinciding
  // with a timeout wins and the timeout pulse is dropped.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_short      = 1'b0;
    w_double     = 1'b0;
    w_long       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_PRESSED;
          w_clear      = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_next = ST_WAIT2;
          w_clear      = 1'b1;
        end else if (w_tc) begin
          w_state_next = ST_LONG;
          w_clear      = 1'b1;
          w_long       = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end
`ifdef BUTTON_REPEAT_EN
        else if (w_tc) begin
          w_clear = 1'b1;
          w_long  = 1'b1;
        end
`endif
      end
      ST_WAIT2: begin
        if (w_rise) begin
          w_state_next = ST_PRESSED2;
          w_clear      = 1'b1;
        end else if (w_tc) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
          w_short      = 1'b1;
        end
      end
      ST_PRESSED2: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
          w_double     = 1'b1;
        end else if (w_tc) begin
          w_state_next = ST_LONG;
          w_clear      = 1'b1;
          w_long       = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  // Button sampler and edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_btn_q   <= w_p;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // State register and classification pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
    end
  end

  assign press        = r_press;
  assign o_release    = r_release;
  assign short_click  = r_short;
  assign double_click = r_double;
  assign long_press   = r_long;
  assign held         = r_btn_q;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event. The whole stimulus (pressed level and
// reset per cycle) is laid out first; expected pulses are then derived from the
// list of press intervals and gaps, and the DUT is compared every cycle.
module tb_button_event;

  localparam int LONG   = 100;
  localparam int DCLICK = 30;
  localparam int REP    = 20;
  localparam int MAXC   = 8000;
  localparam int INF    = 1 << 28;
`ifdef BUTTON_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic btn_in;
  logic press_w, release_w, short_w, double_w, long_w, held_w;

  bit lvl   [MAXC];
  bit inrst [MAXC];
  bit e_press [MAXC];
  bit e_rel   [MAXC];
  bit e_short [MAXC];
  bit e_dbl   [MAXC];
  bit e_long  [MAXC];
  int ncyc   = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event #(
    .ACTIVE_LOW   (1'b1),
    .NBITS        (8),
    .LONG_TICKS   (LONG),
    .DCLICK_TICKS (DCLICK),
    .REPEAT_TICKS (REP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_in       (btn_in),
    .press        (press_w),
    .o_release    (release_w),
    .short_click  (short_w),
    .double_click (double_w),
    .long_press   (long_w),
    .held         (held_w)
  );

  // Append n cycles of a pressed level, optionally with reset held low.
  task automatic add_seg(input bit pressed, input int n, input bit rst = 1'b0);
    for (int i = 0; i < n; i++) begin
      if (ncyc < MAXC) begin
        lvl[ncyc]   = pressed;
        inrst[ncyc] = rst;
        ncyc++;
      end
    end
  endtask

  // Expected pulses from press intervals: a hold longer than LONG is a long
  // press; otherwise a following press starting within DCLICK cycles of the
  // release makes a pair (double click unless the second hold is long),
  // else a short click lands DCLICK cycles after the release.
  task automatic build_model();
    int on_t[$];
    int off_t[$];
    int n, s, e, d, nxt;
    bit prev, second;
    n = 0;
    while (n < ncyc) begin
      if (inrst[n]) begin
        n++;
      end else begin
        s = n;
        e = n;
        while ((e + 1 < ncyc) && !inrst[e+1]) e++;
        on_t.delete();
        off_t.delete();
        for (int c = s; c <= e; c++) begin
          prev = (c == s) ? 1'b0 : lvl[c-1];
          if (lvl[c] && !prev) begin
            e_press[c] = 1'b1;
            on_t.push_back(c);
            off_t.push_back(INF);
          end
          if (!lvl[c] && prev) begin
            e_rel[c] = 1'b1;
            off_t[off_t.size()-1] = c;
          end
        end
        second = 1'b0;
        for (int i = 0; i < on_t.size(); i++) begin
          d = off_t[i] - on_t[i];
          if (d > LONG) begin
            for (int t = on_t[i] + LONG; (t < off_t[i]) && (t <= e); t += REP) begin
              e_long[t] = 1'b1;
              if (!REPEAT_EN) break;
            end
            second = 1'b0;
          end else if (second) begin
            e_dbl[off_t[i]] = 1'b1;
            second = 1'b0;
          end else begin
            nxt = (i + 1 < on_t.size()) ? on_t[i+1] : INF;
            if (nxt - off_t[i] <= DCLICK) second = 1'b1;
            else if (off_t[i] + DCLICK <= e) e_short[off_t[i] + DCLICK] = 1'b1;
          end
        end
        n = e + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input bit exp, input int n);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic apply(input int n);
    reset_n = ~inrst[n];
    btn_in  = ~lvl[n];
  endtask

  initial begin
    reset_n = 1'b0;
    btn_in  = 1'b1;

    // Power-on reset, then idle.
    add_seg(1'b0, 4, 1'b1);
    add_seg(1'b0, 10);
    // Single short click.
    add_seg(1'b1, 10);  add_seg(1'b0, 60);
    // Double click.
    add_seg(1'b1, 10);  add_seg(1'b0, 10);  add_seg(1'b1, 10);  add_seg(1'b0, 60);
    // Long press held 150 cycles.
    add_seg(1'b1, 150); add_seg(1'b0, 60);
    // Reset pulsed mid-WAIT2 with the button held through it.
    add_seg(1'b1, 5);   add_seg(1'b0, 10);  add_seg(1'b1, 3, 1'b1);
    add_seg(1'b1, 20);  add_seg(1'b0, 60);
    // Second press exactly at the double-click timeout, and one cycle later.
    add_seg(1'b1, 10);  add_seg(1'b0, 30);  add_seg(1'b1, 10);  add_seg(1'b0, 60);
    add_seg(1'b1, 10);  add_seg(1'b0, 31);  add_seg(1'b1, 10);  add_seg(1'b0, 60);
    // Release on the long timeout edge, and one cycle after it.
    add_seg(1'b1, 100); add_seg(1'b0, 60);
    add_seg(1'b1, 101); add_seg(1'b0, 60);
    // Second press of a pair that becomes a long press.
    add_seg(1'b1, 5);   add_seg(1'b0, 5);   add_seg(1'b1, 130); add_seg(1'b0, 40);
    // Randomized activity with occasional resets.
    for (int r = 0; r < 30; r++) begin
      add_seg(1'b1, $urandom_range(1, 140));
      add_seg(1'b0, $urandom_range(1, 45));
      if ($urandom_range(0, 9) == 0)
        add_seg(1'($urandom_range(0, 1)), $urandom_range(1, 3), 1'b1);
    end
    add_seg(1'b0, 60);

    build_model();

    apply(0);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      chk("press",        press_w,   e_press[n], n);
      chk("release",      release_w, e_rel[n],   n);
      chk("short_click",  short_w,   e_short[n], n);
      chk("double_click", double_w,  e_dbl[n],   n);
      chk("long_press",   long_w,    e_long[n],  n);
      chk("held",         held_w,    inrst[n] ? 1'b0 : lvl[n], n);
      if (n + 1 < ncyc) apply(n + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
